// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage types and defaults for the instruction fetch controller.
package if_fetch_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    // Low PC bits that must be zero for a word-aligned fetch
    localparam int PC_ALIGN_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer between PREIF, the CPU
// instruction bus and the IF/ID boundary, with flush-safe response dropping.
//
// state | meaning
// IDLE  | no fetch work; ready to accept a PC
// REQ   | request on bus, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// HOLD  | instruction (or address error) held for ID
// DROP  | squashed request in flight; swallow its data_ok
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              preif_req,
    input  logic [ADDR_W-1:0] preif_pc,
    output logic              preif_ready,
    input  logic              flush,
    input  logic              id_allowin,
    output logic              cpu_ibus_req,
    output logic [ADDR_W-1:0] cpu_ibus_addr,
    input  logic              cpu_ibus_addr_ok,
    input  logic              cpu_ibus_data_ok,
    input  logic [DATA_W-1:0] cpu_ibus_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_adel,
    output logic              if_stall_req
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              adel_q, adel_d;
    logic              run_q;

    logic accept;
    logic misalign;

    // run_q keeps preif_ready low for the first cycle after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign preif_ready = run_q && !flush &&
                         ((state_q == IDLE) || ((state_q == HOLD) && id_allowin));
    assign accept      = preif_req && preif_ready;
    assign misalign    = |preif_pc[PC_ALIGN_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        adel_d  = adel_q;

        if (accept) begin
            pc_d = preif_pc;
            if (misalign) begin
                adel_d  = 1'b1;
                instr_d = '0;
                state_d = HOLD;
            end else begin
                adel_d  = 1'b0;
                state_d = REQ;
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                REQ: begin
                    if (flush) begin
                        state_d = cpu_ibus_addr_ok ? DROP : IDLE;
                    end else if (cpu_ibus_addr_ok) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_d = cpu_ibus_data_ok ? IDLE : DROP;
                    end else if (cpu_ibus_data_ok) begin
                        instr_d = cpu_ibus_rdata;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (flush || id_allowin) begin
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (cpu_ibus_data_ok) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            adel_q  <= adel_d;
        end
    end

    assign cpu_ibus_req  = (state_q == REQ);
    assign cpu_ibus_addr = pc_q;
    assign if_valid      = (state_q == HOLD);
    assign if_pc         = pc_q;
    assign if_instr      = instr_q;
    assign if_adel       = adel_q;
    assign if_stall_req  = (state_q == REQ) || (state_q == WAIT) || (state_q == DROP);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl: inputs change #1 after each rising
// edge and outputs are checked once the combinational paths have settled.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        preif_req;
    logic [31:0] preif_pc;
    logic        preif_ready;
    logic        flush;
    logic        id_allowin;
    logic        cpu_ibus_req;
    logic [31:0] cpu_ibus_addr;
    logic        cpu_ibus_addr_ok;
    logic        cpu_ibus_data_ok;
    logic [31:0] cpu_ibus_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;
    logic        if_stall_req;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .preif_req        (preif_req),
        .preif_pc         (preif_pc),
        .preif_ready      (preif_ready),
        .flush            (flush),
        .id_allowin       (id_allowin),
        .cpu_ibus_req     (cpu_ibus_req),
        .cpu_ibus_addr    (cpu_ibus_addr),
        .cpu_ibus_addr_ok (cpu_ibus_addr_ok),
        .cpu_ibus_data_ok (cpu_ibus_data_ok),
        .cpu_ibus_rdata   (cpu_ibus_rdata),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .if_adel          (if_adel),
        .if_stall_req     (if_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn           = 1'b0;
        preif_req        = 1'b0;
        preif_pc         = 32'h0;
        flush            = 1'b0;
        id_allowin       = 1'b0;
        cpu_ibus_addr_ok = 1'b0;
        cpu_ibus_data_ok = 1'b0;
        cpu_ibus_rdata   = 32'h0;

        // reset values
        settle();
        chk("rst_ready", 32'(preif_ready), 32'd0);
        chk("rst_req", 32'(cpu_ibus_req), 32'd0);
        chk("rst_addr", cpu_ibus_addr, 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_adel", 32'(if_adel), 32'd0);
        chk("rst_stall", 32'(if_stall_req), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        settle();
        chk("post_rel_ready", 32'(preif_ready), 32'd0);
        chk("post_rel_valid", 32'(if_valid), 32'd0);

        // cycle N: accept 0xBFC00000
        tick();
        preif_req  = 1'b1;
        preif_pc   = 32'hBFC0_0000;
        id_allowin = 1'b1;
        settle();
        chk("n_ready", 32'(preif_ready), 32'd1);
        chk("n_req", 32'(cpu_ibus_req), 32'd0);
        // N+1: request on bus, addr_ok immediately
        tick();
        preif_req        = 1'b0;
        cpu_ibus_addr_ok = 1'b1;
        settle();
        chk("n1_req", 32'(cpu_ibus_req), 32'd1);
        chk("n1_addr", cpu_ibus_addr, 32'hBFC0_0000);
        chk("n1_stall", 32'(if_stall_req), 32'd1);
        chk("n1_ready", 32'(preif_ready), 32'd0);
        // N+2: data returns
        tick();
        cpu_ibus_addr_ok = 1'b0;
        cpu_ibus_data_ok = 1'b1;
        cpu_ibus_rdata   = 32'h3C08_0001;
        settle();
        chk("n2_req", 32'(cpu_ibus_req), 32'd0);
        chk("n2_valid", 32'(if_valid), 32'd0);
        // N+3: instruction presented
        tick();
        cpu_ibus_data_ok = 1'b0;
        cpu_ibus_rdata   = 32'h0;
        settle();
        chk("n3_valid", 32'(if_valid), 32'd1);
        chk("n3_instr", if_instr, 32'h3C08_0001);
        chk("n3_pc", if_pc, 32'hBFC0_0000);
        chk("n3_adel", 32'(if_adel), 32'd0);
        chk("n3_ready", 32'(preif_ready), 32'd1);
        chk("n3_stall", 32'(if_stall_req), 32'd0);

        // HOLD with ID stalled
        id_allowin = 1'b0;
        settle();
        chk("hold_ready0", 32'(preif_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_instr", if_instr, 32'h3C08_0001);
            chk("hold_ready", 32'(preif_ready), 32'd0);
            chk("hold_req", 32'(cpu_ibus_req), 32'd0);
        end
        // back-to-back accept from HOLD
        id_allowin = 1'b1;
        preif_req  = 1'b1;
        preif_pc   = 32'hBFC0_0004;
        settle();
        chk("b2b_ready", 32'(preif_ready), 32'd1);
        tick();
        preif_req        = 1'b0;
        cpu_ibus_addr_ok = 1'b1;
        settle();
        chk("b2b_req", 32'(cpu_ibus_req), 32'd1);
        chk("b2b_addr", cpu_ibus_addr, 32'hBFC0_0004);
        chk("b2b_valid", 32'(if_valid), 32'd0);

        // flush in WAIT, data arrives three cycles after address
        tick();
        cpu_ibus_addr_ok = 1'b0;
        flush            = 1'b1;
        settle();
        chk("wflush_req", 32'(cpu_ibus_req), 32'd0);
        chk("wflush_ready", 32'(preif_ready), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("drop_stall", 32'(if_stall_req), 32'd1);
        chk("drop_ready", 32'(preif_ready), 32'd0);
        chk("drop_valid", 32'(if_valid), 32'd0);
        tick();
        flush = 1'b1;
        settle();
        chk("drop_flush_stall", 32'(if_stall_req), 32'd1);
        tick();
        flush            = 1'b0;
        cpu_ibus_data_ok = 1'b1;
        cpu_ibus_rdata   = 32'hDEAD_BEEF;
        preif_req        = 1'b1;
        preif_pc         = 32'h8000_0180;
        settle();
        chk("drop_data_ready", 32'(preif_ready), 32'd0);
        chk("drop_data_valid", 32'(if_valid), 32'd0);
        tick();
        cpu_ibus_data_ok = 1'b0;
        cpu_ibus_rdata   = 32'h0;
        settle();
        chk("after_drop_valid", 32'(if_valid), 32'd0);
        chk("after_drop_stall", 32'(if_stall_req), 32'd0);
        chk("after_drop_ready", 32'(preif_ready), 32'd1);
        tick();
        preif_req        = 1'b0;
        cpu_ibus_addr_ok = 1'b1;
        settle();
        chk("f180_req", 32'(cpu_ibus_req), 32'd1);
        chk("f180_addr", cpu_ibus_addr, 32'h8000_0180);
        tick();
        cpu_ibus_addr_ok = 1'b0;
        cpu_ibus_data_ok = 1'b1;
        cpu_ibus_rdata   = 32'h2402_0001;
        tick();
        cpu_ibus_data_ok = 1'b0;
        cpu_ibus_rdata   = 32'h0;
        settle();
        chk("f180_valid", 32'(if_valid), 32'd1);
        chk("f180_instr", if_instr, 32'h2402_0001);
        chk("f180_pc", if_pc, 32'h8000_0180);

        // back-to-back into REQ, then flush before addr_ok
        preif_req = 1'b1;
        preif_pc  = 32'hBFC0_0010;
        tick();
        preif_req = 1'b0;
        flush     = 1'b1;
        settle();
        chk("rflush_req", 32'(cpu_ibus_req), 32'd1);
        chk("rflush_addr", cpu_ibus_addr, 32'hBFC0_0010);
        chk("rflush_ready", 32'(preif_ready), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("rflush_req_off", 32'(cpu_ibus_req), 32'd0);
        chk("rflush_stall", 32'(if_stall_req), 32'd0);
        chk("rflush_idle_ready", 32'(preif_ready), 32'd1);

        // misaligned PC: no bus request, address error held
        preif_req = 1'b1;
        preif_pc  = 32'hBFC0_0002;
        settle();
        chk("adel_accept", 32'(preif_ready), 32'd1);
        tick();
        preif_req  = 1'b0;
        id_allowin = 1'b0;
        settle();
        chk("adel_req", 32'(cpu_ibus_req), 32'd0);
        chk("adel_valid", 32'(if_valid), 32'd1);
        chk("adel_flag", 32'(if_adel), 32'd1);
        chk("adel_instr", if_instr, 32'd0);
        chk("adel_pc", if_pc, 32'hBFC0_0002);
        chk("adel_stall", 32'(if_stall_req), 32'd0);
        // flush in HOLD: valid still shown this cycle, gone next
        flush = 1'b1;
        settle();
        chk("hflush_valid", 32'(if_valid), 32'd1);
        chk("hflush_ready", 32'(preif_ready), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("hflush_valid_off", 32'(if_valid), 32'd0);

        // asynchronous reset while in WAIT, then a late data_ok
        preif_req = 1'b1;
        preif_pc  = 32'hBFC0_0020;
        tick();
        preif_req        = 1'b0;
        cpu_ibus_addr_ok = 1'b1;
        tick();
        cpu_ibus_addr_ok = 1'b0;
        settle();
        chk("wait_stall", 32'(if_stall_req), 32'd1);
        resetn = 1'b0;
        settle();
        chk("arst_stall", 32'(if_stall_req), 32'd0);
        chk("arst_req", 32'(cpu_ibus_req), 32'd0);
        chk("arst_addr", cpu_ibus_addr, 32'd0);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_ready", 32'(preif_ready), 32'd0);
        tick();
        resetn = 1'b1;
        settle();
        chk("arst_rel_ready", 32'(preif_ready), 32'd0);
        tick();
        cpu_ibus_data_ok = 1'b1;
        cpu_ibus_rdata   = 32'h1234_5678;
        tick();
        cpu_ibus_data_ok = 1'b0;
        cpu_ibus_rdata   = 32'h0;
        settle();
        chk("late_valid", 32'(if_valid), 32'd0);
        chk("late_instr", if_instr, 32'd0);
        chk("late_stall", 32'(if_stall_req), 32'd0);
        chk("late_ready", 32'(preif_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
